key_led_ctrl: RTL and testbench

- Sits directly downstream of the key debounce filter; consumes its one-cycle key_flag pulse and its key_state level (0 = pressed, 1 = released).
- Classifies each debounced gesture as a single click, double click or long press.
- Uses the result to drive an LED mode/pattern engine: off, steady, flash or chase, at slow or fast speed.

---
 rtl/key_led_pkg.sv | 30 +++
 rtl/key_led_pattern_gen.sv | 65 ++++++
 rtl/key_led_ctrl.sv | 142 ++++++++++++++
 tb/tb_key_led_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_led_pkg.sv
// Shared state, event and mode encodings for the key gesture / LED controller.
package key_led_pkg;

   typedef enum logic [4:0] {
      IDLE      = 5'b00001,
      PRESSED   = 5'b00010,
      WAIT2     = 5'b00100,
      PRESSED2  = 5'b01000,
      LONG_HOLD = 5'b10000
   } state_e;

   localparam logic [1:0] EVT_SINGLE = 2'b01;
   localparam logic [1:0] EVT_DOUBLE = 2'b10;
   localparam logic [1:0] EVT_LONG   = 2'b11;

   localparam logic [1:0] MODE_OFF    = 2'd0;
   localparam logic [1:0] MODE_STEADY = 2'd1;
   localparam logic [1:0] MODE_FLASH  = 2'd2;
   localparam logic [1:0] MODE_CHASE  = 2'd3;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Single click walks OFF->STEADY->FLASH->CHASE, then cycles back to STEADY.
   function automatic logic [1:0] next_mode(input logic [1:0] m);
      return (m == MODE_CHASE) ? MODE_STEADY : m + 2'd1;
   endfunction

endpackage

// File: rtl/key_led_pattern_gen.sv
// LED pattern engine: half-period tick counter and LED register.
// Pattern restarts from its initial phase whenever mode or speed changes.
module led_pattern_gen
   import key_led_pkg::*;
#(
   parameter int unsigned FLASH_CYC = 12_500_000,
   parameter int unsigned LED_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode_i,
   input  logic             fast_i,
   output logic [LED_W-1:0] led_o
);

   localparam int unsigned SLOW_HP = max_u(FLASH_CYC, 1);
   localparam int unsigned FAST_HP = max_u(FLASH_CYC / 4, 1);
   localparam int unsigned TICK_W  = max_u($clog2(SLOW_HP), 1);

   logic [TICK_W-1:0] tick_q, tick_d, tick_last;
   logic [LED_W-1:0]  led_q, led_d, led_start;
   logic [1:0]        mode_seen_q;
   logic              fast_seen_q;
   logic              changed;

   always_comb begin
      tick_last = fast_i ? TICK_W'(FAST_HP - 1) : TICK_W'(SLOW_HP - 1);
      changed   = (mode_i != mode_seen_q) || (fast_i != fast_seen_q);
      case (mode_i)
         MODE_OFF:   led_start = '0;
         MODE_CHASE: led_start = LED_W'(1);
         default:    led_start = '1;
      endcase
      tick_d = tick_q + TICK_W'(1);
      led_d  = led_q;
      if (changed) begin
         tick_d = '0;
         led_d  = led_start;
      end else if (tick_q == tick_last) begin
         tick_d = '0;
         case (mode_i)
            MODE_FLASH: led_d = ~led_q;
            MODE_CHASE: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
            default:    led_d = led_start;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q      <= '0;
         led_q       <= '0;
         mode_seen_q <= MODE_OFF;
         fast_seen_q <= 1'b0;
      end else begin
         tick_q      <= tick_d;
         led_q       <= led_d;
         mode_seen_q <= mode_i;
         fast_seen_q <= fast_i;
      end
   end

   assign led_o = led_q;

endmodule

// File: rtl/key_led_ctrl.sv
// Key gesture classifier (single / double / long) driving LED mode and speed.
// Define KEY_LED_DBL_EN to enable double-click detection.
module key_led_ctrl
   import key_led_pkg::*;
#(
   parameter int unsigned LONG_CYC  = 50_000_000,
   parameter int unsigned DBL_CYC   = 15_000_000,
   parameter int unsigned FLASH_CYC = 12_500_000,
   parameter int unsigned LED_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_flag,
   input  logic             key_state,
   output logic             evt_valid,
   output logic [1:0]       evt_code,
   output logic [1:0]       mode,
   output logic             fast,
   output logic [LED_W-1:0] led
);

   localparam int unsigned CNT_W = $clog2(max_u(max_u(LONG_CYC, DBL_CYC), 2));
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);

   logic             key_press, key_rel;
   state_e           state_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic             evt_valid_q;
   logic [1:0]       evt_code_q;
   logic [1:0]       mode_q;
   logic             fast_q;
`ifdef KEY_LED_DBL_EN
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DBL_CYC - 1);
   logic [CNT_W-1:0] gap_cnt_q;
`endif

   assign key_press = key_flag & ~key_state;
   assign key_rel   = key_flag &  key_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_cnt_q  <= '0;
         evt_valid_q <= 1'b0;
         evt_code_q  <= 2'b00;
         mode_q      <= MODE_OFF;
         fast_q      <= 1'b0;
`ifdef KEY_LED_DBL_EN
         gap_cnt_q   <= '0;
`endif
      end else begin
         evt_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (key_press) begin
                  state_q    <= PRESSED;
                  hold_cnt_q <= '0;
               end
            end
            PRESSED: begin
               hold_cnt_q <= hold_cnt_q + CNT_W'(1);
               // Release beats the long-press timeout in the same cycle.
               if (key_rel) begin
`ifdef KEY_LED_DBL_EN
                  state_q   <= WAIT2;
                  gap_cnt_q <= '0;
`else
                  state_q     <= IDLE;
                  evt_valid_q <= 1'b1;
                  evt_code_q  <= EVT_SINGLE;
`endif
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_q     <= LONG_HOLD;
                  evt_valid_q <= 1'b1;
                  evt_code_q  <= EVT_LONG;
               end
            end
`ifdef KEY_LED_DBL_EN
            WAIT2: begin
               gap_cnt_q <= gap_cnt_q + CNT_W'(1);
               if (key_press) begin
                  state_q    <= PRESSED2;
                  hold_cnt_q <= '0;
               end else if (gap_cnt_q == GAP_LAST) begin
                  state_q     <= IDLE;
                  evt_valid_q <= 1'b1;
                  evt_code_q  <= EVT_SINGLE;
               end
            end
            PRESSED2: begin
               hold_cnt_q <= hold_cnt_q + CNT_W'(1);
               if (key_rel) begin
                  state_q     <= IDLE;
                  evt_valid_q <= 1'b1;
                  evt_code_q  <= EVT_DOUBLE;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_q     <= LONG_HOLD;
                  evt_valid_q <= 1'b1;
                  evt_code_q  <= EVT_DOUBLE;
               end
            end
`endif
            LONG_HOLD: begin
               if (key_rel) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         // Mode/speed follow the event one cycle after the strobe.
         if (evt_valid_q) begin
            case (evt_code_q)
               EVT_SINGLE: mode_q <= next_mode(mode_q);
`ifdef KEY_LED_DBL_EN
               EVT_DOUBLE: fast_q <= ~fast_q;
`endif
               EVT_LONG: begin
                  mode_q <= MODE_OFF;
                  fast_q <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   led_pattern_gen #(
      .FLASH_CYC (FLASH_CYC),
      .LED_W     (LED_W)
   ) u_pattern (
      .clk    (clk),
      .rst    (rst),
      .mode_i (mode_q),
      .fast_i (fast_q),
      .led_o  (led)
   );

   assign evt_valid = evt_valid_q;
   assign evt_code  = evt_code_q;
   assign mode      = mode_q;
   assign fast      = fast_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Self-checking bench for key_led_ctrl: timestamp-based gesture model plus directed scenarios.
module tb_key_led_ctrl;

   localparam int unsigned LONG_CYC  = 100;
   localparam int unsigned DBL_CYC   = 40;
   localparam int unsigned FLASH_CYC = 8;
   localparam int unsigned LED_W     = 4;
   localparam int FAST_HP = (FLASH_CYC / 4 > 0) ? int'(FLASH_CYC / 4) : 1;
`ifdef KEY_LED_DBL_EN
   localparam int SINGLE_LAT = int'(DBL_CYC);
   localparam int CHASE_HP   = FAST_HP;
`else
   localparam int SINGLE_LAT = 0;
   localparam int CHASE_HP   = int'(FLASH_CYC);
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             key_flag;
   logic             key_state;
   logic             evt_valid;
   logic [1:0]       evt_code;
   logic [1:0]       mode;
   logic             fast;
   logic [LED_W-1:0] led;

   int n_chk  = 0;
   int n_pass = 0;
   int n_evt  = 0;

   key_led_ctrl #(
      .LONG_CYC  (LONG_CYC),
      .DBL_CYC   (DBL_CYC),
      .FLASH_CYC (FLASH_CYC),
      .LED_W     (LED_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_flag  (key_flag),
      .key_state (key_state),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .mode      (mode),
      .fast      (fast),
      .led       (led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   // ---------------- reference model ----------------
   int n = 0;
   int t_p1, t_r1, t_p2, led_start;
   bit lwait, pending;
   int m_mode, m_code;
   bit m_fast, m_valid;
   logic [LED_W-1:0] m_led;

   function automatic logic [LED_W-1:0] led_of(input int md, input bit fs, input int el);
      int hp;
      int k;
      logic [LED_W-1:0] one;
      hp  = fs ? FAST_HP : int'(FLASH_CYC);
      k   = el / hp;
      one = LED_W'(1);
      case (md)
         0:       return '0;
         1:       return '1;
         2:       return (k % 2 == 0) ? '1 : '0;
         default: return one << (k % LED_W);
      endcase
   endfunction

   task automatic emit(input int code);
      m_valid = 1'b1;
      m_code  = code;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         t_p1 = -1; t_r1 = -1; t_p2 = -1;
         lwait = 0; pending = 0; led_start = n;
         m_mode = 0; m_fast = 0; m_valid = 0; m_code = 0; m_led = '0;
      end else begin
         bit prs, rl;
         int old_mode;
         bit old_fast;
         n++;
         prs = key_flag & ~key_state;
         rl  = key_flag & key_state;
         // led engine sees mode/fast as they were before this edge
         if (pending) begin
            led_start = n;
            pending   = 0;
         end
         m_led = led_of(m_mode, m_fast, n - led_start);
         old_mode = m_mode;
         old_fast = m_fast;
         if (m_valid) begin
            if (m_code == 1)      m_mode = (m_mode == 3) ? 1 : m_mode + 1;
            else if (m_code == 2) m_fast = !m_fast;
            else if (m_code == 3) begin m_mode = 0; m_fast = 0; end
         end
         if (m_mode != old_mode || m_fast != old_fast) pending = 1;
         m_valid = 0;
         if (t_p1 >= 0 && t_r1 < 0) begin
            if (rl) begin
`ifdef KEY_LED_DBL_EN
               t_r1 = n;
`else
               emit(1); t_p1 = -1;
`endif
            end else if (n - t_p1 == int'(LONG_CYC)) begin
               emit(3); t_p1 = -1; lwait = 1;
            end
         end
`ifdef KEY_LED_DBL_EN
         else if (t_r1 >= 0 && t_p2 < 0) begin
            if (prs) t_p2 = n;
            else if (n - t_r1 == int'(DBL_CYC)) begin
               emit(1); t_p1 = -1; t_r1 = -1;
            end
         end else if (t_p2 >= 0) begin
            if (rl) begin
               emit(2); t_p1 = -1; t_r1 = -1; t_p2 = -1;
            end else if (n - t_p2 == int'(LONG_CYC)) begin
               emit(2); t_p1 = -1; t_r1 = -1; t_p2 = -1; lwait = 1;
            end
         end
`endif
         else if (lwait) begin
            if (rl) lwait = 0;
         end else if (prs) t_p1 = n;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (evt_valid === 1'b1) n_evt++;
      chk("cyc_evt_valid", evt_valid, m_valid);
      chk("cyc_evt_code",  evt_code,  m_code);
      chk("cyc_mode",      mode,      m_mode);
      chk("cyc_fast",      fast,      m_fast);
      chk("cyc_led",       led,       m_led);
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic key_evt(input logic st, output int edge_n);
      key_flag  = 1'b1;
      key_state = st;
      @(posedge clk);
      #1;
      edge_n   = n;
      key_flag = 1'b0;
   endtask

   task automatic expect_evt(input string nm, input int code, input int ref_e, input int lat,
                             input int lim);
      bit got;
      got = 0;
      for (int i = 0; i < lim && !got; i++) begin
         @(negedge clk);
         if (evt_valid === 1'b1) got = 1;
      end
      chk({nm, "_seen"}, got, 1);
      if (got) begin
         chk({nm, "_latency"}, n - ref_e, lat);
         chk({nm, "_code"}, evt_code, code);
      end
   endtask

   task automatic no_evt(input string nm, input int k);
      int c0;
      c0 = n_evt;
      idle(k);
      chk(nm, n_evt - c0, 0);
   endtask

   task automatic click();
      int p, r;
      key_evt(1'b0, p);
      idle(19);
      key_evt(1'b1, r);
      expect_evt("single", 1, r, SINGLE_LAT, 100);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int p, r, r2, c0;
      logic [LED_W-1:0] ex;
      rst = 1'b1; key_flag = 1'b0; key_state = 1'b1;
      idle(3);
      chk("rst_evt_valid", evt_valid, 0);
      chk("rst_evt_code",  evt_code,  0);
      chk("rst_mode",      mode,      0);
      chk("rst_fast",      fast,      0);
      chk("rst_led",       led,       0);
      rst = 1'b0;
      idle(5);

      // single click -> STEADY
      click();
      idle(1); chk("s1_mode", mode, 1);
      idle(1); chk("s1_led", led, 4'b1111);
      idle(10);

      // second single -> FLASH, slow half-period
      click();
      idle(1); chk("s2_mode", mode, 2);
      idle(1); chk("flash_ph0", led, 4'b1111);
      idle(int'(FLASH_CYC)); chk("flash_ph1", led, 4'b0000);
      idle(int'(FLASH_CYC)); chk("flash_ph2", led, 4'b1111);

`ifdef KEY_LED_DBL_EN
      // double click toggles speed, mode unchanged
      c0 = n_evt;
      key_evt(1'b0, p); idle(19); key_evt(1'b1, r);
      idle(9); key_evt(1'b0, p); idle(9); key_evt(1'b1, r2);
      expect_evt("double", 2, r2, 0, 10);
      idle(1);
      chk("dbl_fast", fast, 1);
      chk("dbl_mode", mode, 2);
      chk("dbl_evt_count", n_evt - c0, 1);
      idle(10);
`endif

      // third single -> CHASE
      click();
      idle(1); chk("s3_mode", mode, 3);
      idle(1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) idle(CHASE_HP);
         ex = LED_W'(1);
         ex = ex << (i % LED_W);
         chk("chase_step", led, ex);
      end

      // fourth single wraps to STEADY
      click();
      idle(1); chk("s4_mode", mode, 1);
      idle(10);

      // long press
      key_evt(1'b0, p);
      expect_evt("long", 3, p, int'(LONG_CYC), int'(LONG_CYC) + 20);
      idle(2);
      chk("long_mode", mode, 0);
      chk("long_fast", fast, 0);
      chk("long_led",  led,  0);
      key_evt(1'b1, r);
      no_evt("long_release_quiet", 60);

`ifdef KEY_LED_DBL_EN
      // press on the last gap cycle still counts as a double click
      c0 = n_evt;
      key_evt(1'b0, p); idle(19); key_evt(1'b1, r);
      idle(int'(DBL_CYC) - 1); key_evt(1'b0, p);
      idle(9); key_evt(1'b1, r2);
      expect_evt("gap_edge", 2, r2, 0, 5);
      chk("gap_edge_count", n_evt - c0, 1);
      idle(10);
`endif

      // release on the last hold cycle beats the long press
      key_evt(1'b0, p);
      idle(int'(LONG_CYC) - 1);
      key_evt(1'b1, r);
      expect_evt("hold_edge", 1, r, SINGLE_LAT, 60);
      idle(10);

      // reset mid-hold aborts the gesture
      key_evt(1'b0, p);
      idle(30);
      rst = 1'b1;
      #1;
      chk("mid_rst_evt_valid", evt_valid, 0);
      chk("mid_rst_evt_code",  evt_code,  0);
      chk("mid_rst_mode",      mode,      0);
      chk("mid_rst_fast",      fast,      0);
      chk("mid_rst_led",       led,       0);
      idle(3);
      rst = 1'b0;
      idle(2);
      key_evt(1'b1, r);
      no_evt("post_rst_quiet", 60);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
